qar_irq_ctrl: RTL and testbench

QAR_IRQ_CTRL -- requirements
Module: qar_irq_ctrl

---
 rtl/qar_irq_pkg.sv | 10 +
 rtl/qar_irq_if.sv | 11 +
 rtl/qar_irq_prio.sv | 17 +
 rtl/qar_irq_ctrl.sv | 89 ++++++++
 tb/tb_qar_irq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/qar_irq_pkg.sv
// qar_irq_pkg: register offsets, FSM state encodings and ID width shared by the interrupt controller
package qar_irq_pkg;
  localparam int ID_W = 5;
  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_CLAIM   = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
endpackage

// File: rtl/qar_irq_if.sv
// qar_irq_if: single-cycle register bus between a bus master and the interrupt controller
interface qar_irq_if;
  logic        valid;
  logic        we;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output valid, we, addr, wdata, input ready, rdata);
  modport slave (input valid, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/qar_irq_prio.sv
// qar_irq_prio: combinational lowest-index priority encoder, bit i reported as ID i+1
module qar_irq_prio
  import qar_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);
  // scan downward so the lowest set index is the last assignment and wins
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) id = req[i] ? ID_W'(i + 1) : id;
  end
  assign valid = |req;
endmodule

// File: rtl/qar_irq_ctrl.sv
// qar_irq_ctrl: edge/level interrupt controller with claim/complete handshake; QAR_IRQ_SYNC_EN adds a two-flop input synchronizer
module qar_irq_ctrl
  import qar_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_external,
  input  logic               irq_external_ack,
  qar_irq_if.slave           bus
);
  state_t state, state_n;
  logic [NUM_SRC-1:0] src_s, hist, pend, en, edge_cfg, excl, elig, w1c, clr;
  logic [ID_W-1:0] claim_id, win_id;
  logic win_valid, ack_q, take, done, wr;
  logic [2:0] off;
  logic unused_addr;
  assign off = bus.addr[4:2];
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};
  assign wr = bus.valid & bus.we;
  assign bus.ready = bus.valid;
`ifdef QAR_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  // two-flop synchronizer for asynchronous source lines
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif
  // the claimed source stays out of arbitration until it is completed
  assign excl = state == SERVICE ? NUM_SRC'(1) << (claim_id - 1'b1) : '0;
  assign clr = take ? NUM_SRC'(1) << (win_id - 1'b1) : '0;
  assign w1c = (wr && off == OFF_PENDING) ? bus.wdata[NUM_SRC-1:0] : '0;
  assign elig = pend & en & ~excl;
  qar_irq_prio #(.N(NUM_SRC)) u_prio (.req(elig), .valid(win_valid), .id(win_id));
  // next-state: claim on ack rising edge, withdraw when nothing is eligible, complete on matching CLAIM write
  always_comb begin
    state_n = state;
    take = 1'b0;
    done = state == SERVICE && wr && off == OFF_CLAIM && bus.wdata == 32'(claim_id);
    if (state == IDLE && win_valid) state_n = REQ;
    if (state == REQ && !win_valid) state_n = IDLE;
    if (state == REQ && win_valid && irq_external_ack && !ack_q) begin
      take = 1'b1;
      state_n = SERVICE;
    end
    if (done) state_n = IDLE;
  end
  // state, registered request line, ack history and claimed ID
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      irq_external <= 1'b0;
      ack_q <= 1'b0;
      claim_id <= '0;
    end else begin
      state <= state_n;
      irq_external <= state_n == REQ;
      ack_q <= irq_external_ack;
      claim_id <= take ? win_id : done ? '0 : claim_id;
    end
  // pending latch (edge set beats any clear), config registers and edge history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      pend <= '0;
      en <= '0;
      edge_cfg <= '0;
    end else begin
      hist <= src_s;
      pend <= (edge_cfg & ((pend & ~w1c & ~clr) | (src_s & ~hist))) | (~edge_cfg & src_s);
      en <= (wr && off == OFF_ENABLE) ? bus.wdata[NUM_SRC-1:0] : en;
      edge_cfg <= (wr && off == OFF_EDGE) ? bus.wdata[NUM_SRC-1:0] : edge_cfg;
    end
  assign bus.rdata = off == OFF_PENDING ? 32'(pend) :
                     off == OFF_ENABLE  ? 32'(en) :
                     off == OFF_EDGE    ? 32'(edge_cfg) :
                     off == OFF_CLAIM   ? 32'(claim_id) :
                     off == OFF_STATUS  ? {19'b0, claim_id, 6'b0, state} : '0;
endmodule

// File: tb/tb_qar_irq_ctrl.sv
// tb_qar_irq_ctrl: directed scoreboard bench for qar_irq_ctrl
module tb_qar_irq_ctrl;
  typedef struct {
    logic [31:0] v;
    string       n;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, ack = 1'b0, irq, probe = 1'b0;
  logic [7:0] src = '0;
  exp_t q[$];
  int vectors = 0, miss = 0;
  qar_irq_if bus();
  qar_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .irq_src(src), .irq_external(irq),
    .irq_external_ack(ack), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input logic [31:0] act);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miss++;
      $display("FAIL underflow: got %h with no expected value queued", act);
      return;
    end
    e = q.pop_front();
    if (act !== e.v) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", e.n, act, e.v);
    end
  endtask
  always @(negedge clk) begin
    if (probe) check({31'b0, irq});
    if (bus.valid && !bus.we && bus.ready) check(bus.rdata);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.valid = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    cyc();
    bus.valid = 1'b0; bus.we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    q.push_back('{e, n});
    bus.valid = 1'b1; bus.we = 1'b0; bus.addr = a;
    cyc();
    bus.valid = 1'b0;
  endtask
  task automatic chk_irq(input logic e, input string n);
    q.push_back('{{31'b0, e}, n});
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask
  task automatic pulse_src(input logic [7:0] m);
    src = m;
    cyc();
    src = '0;
  endtask
  task automatic pulse_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    rd(32'h00, 32'h0, "rst_pending");
    rd(32'h04, 32'h0, "rst_enable");
    rd(32'h10, 32'h0, "rst_status");
    chk_irq(1'b0, "rst_irq");
    // single edge source: request, claim, complete
    wr(32'h08, 32'h01);
    wr(32'h04, 32'h01);
    pulse_src(8'h01);
    repeat (4) cyc();
    chk_irq(1'b1, "t1_irq");
    rd(32'h10, 32'h1, "t1_status_req");
    pulse_ack();
    rd(32'h0C, 32'h1, "t1_claim");
    rd(32'h00, 32'h0, "t1_pending_cleared");
    chk_irq(1'b0, "t1_irq_service");
    rd(32'h10, 32'h102, "t1_status_service");
    wr(32'h0C, 32'h1);
    rd(32'h10, 32'h0, "t1_status_done");
    // two edge sources fired together: ID 3 then ID 6
    wr(32'h08, 32'hFF);
    wr(32'h04, 32'hFF);
    rd(32'h04, 32'hFF, "enable_rw");
    rd(32'h14, 32'h0, "unmapped_14");
    rd(32'h1C, 32'h0, "unmapped_1c");
    pulse_src(8'h24);
    repeat (4) cyc();
    rd(32'h00, 32'h24, "t2_pending");
    chk_irq(1'b1, "t2_irq");
    pulse_ack();
    rd(32'h0C, 32'h3, "t2_claim3");
    rd(32'h00, 32'h20, "t2_pending_after");
    chk_irq(1'b0, "t2_irq_service");
    wr(32'h0C, 32'h3);
    repeat (2) cyc();
    chk_irq(1'b1, "t2_irq_second");
    pulse_ack();
    rd(32'h0C, 32'h6, "t2_claim6");
    wr(32'h0C, 32'h6);
    rd(32'h00, 32'h0, "t2_pending_empty");
    // level source 2 held high
    wr(32'h04, 32'h0);
    wr(32'h08, 32'h0);
    src = 8'h02;
    wr(32'h04, 32'h02);
    repeat (4) cyc();
    chk_irq(1'b1, "t3_irq");
    pulse_ack();
    rd(32'h10, 32'h202, "t3_service");
    wr(32'h00, 32'h02);
    rd(32'h00, 32'h02, "t3_level_w1c_ignored");
    wr(32'h0C, 32'h5);
    rd(32'h10, 32'h202, "t3_bad_complete");
    wr(32'h0C, 32'h2);
    rd(32'h10, 32'h0, "t3_complete_idle");
    rd(32'h10, 32'h1, "t3_rerequest");
    chk_irq(1'b1, "t3_irq_again");
    src = '0;
    wr(32'h04, 32'h0);
    repeat (3) cyc();
    rd(32'h10, 32'h0, "t3_drop_idle");
    // withdraw the request by disabling before ack
    wr(32'h08, 32'h01);
    wr(32'h04, 32'h01);
    pulse_src(8'h01);
    repeat (4) cyc();
    chk_irq(1'b1, "t4_irq_before");
    wr(32'h04, 32'h0);
    cyc();
    chk_irq(1'b0, "t4_irq_dropped");
    rd(32'h10, 32'h0, "t4_status");
    rd(32'h0C, 32'h0, "t4_claim");
    rd(32'h00, 32'h1, "t4_pending_kept");
    wr(32'h00, 32'h1);
    rd(32'h00, 32'h0, "t4_w1c");
    // edge set in the same cycle as a W1C of that bit
    src = 8'h01;
    wr(32'h00, 32'h1);
    src = '0;
    rd(32'h00, 32'h1, "set_beats_w1c");
    wr(32'h00, 32'h1);
    rd(32'h00, 32'h0, "set_then_clear");
    // ack held high for 10 cycles across a complete and a new request
    wr(32'h08, 32'h03);
    wr(32'h04, 32'h03);
    pulse_src(8'h03);
    repeat (4) cyc();
    chk_irq(1'b1, "t5_irq");
    ack = 1'b1;
    cyc();
    rd(32'h0C, 32'h1, "t5_claim1");
    wr(32'h0C, 32'h1);
    repeat (2) cyc();
    rd(32'h10, 32'h1, "t5_req_unclaimed");
    repeat (3) cyc();
    rd(32'h0C, 32'h0, "t5_still_unclaimed");
    ack = 1'b0;
    cyc();
    chk_irq(1'b1, "t5_irq_after_hold");
    pulse_ack();
    rd(32'h0C, 32'h2, "t5_claim2");
    wr(32'h0C, 32'h2);
    rd(32'h10, 32'h0, "t5_done");
    // asynchronous reset while in SERVICE
    wr(32'h08, 32'h01);
    wr(32'h04, 32'h01);
    pulse_src(8'h01);
    repeat (4) cyc();
    pulse_ack();
    rd(32'h10, 32'h102, "t6_pre_rst");
    #1;
    rst = 1'b1;
    q.push_back('{32'h0, "t6_async_irq"});
    q.push_back('{32'h0, "t6_async_status"});
    probe = 1'b1;
    bus.valid = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
    cyc();
    probe = 1'b0;
    bus.valid = 1'b0;
    rd(32'h00, 32'h0, "t6_pending");
    rd(32'h04, 32'h0, "t6_enable");
    rd(32'h08, 32'h0, "t6_edge");
    rd(32'h0C, 32'h0, "t6_claim");
    rst = 1'b0;
    cyc();
    rd(32'h10, 32'h0, "t6_post_rst");
    repeat (3) cyc();
    if (q.size() != 0) begin
      $display("FAIL leftover: %0d expected responses never presented, expected 0", q.size());
      vectors += q.size();
      miss += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
